// File: rtl/instruction_fetch_unit_if.sv
// Loader/sequencer bus between the program loader, the controller and the
// instruction fetch unit; clock and reset stay outside as plain ports.
interface instruction_fetch_unit_if #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = $clog2(IMEM_DEPTH)
) ();
  logic          load_valid_in;
  logic [7:0]    load_byte_in;
  logic          load_ready_out;
  logic          load_done_in;
  logic          start_in;
  logic          halt_in;
  logic [31:0]   current_instruction_out;
  logic          instruction_valid_out;
  logic [AW-1:0] program_counter_out;
  logic [AW:0]   program_length_out;
  logic          load_error_out;
  logic          busy_out;
  logic          done_out;

  modport master (
    output load_valid_in, load_byte_in, load_done_in, start_in, halt_in,
    input  load_ready_out, current_instruction_out, instruction_valid_out,
           program_counter_out, program_length_out, load_error_out,
           busy_out, done_out
  );

  modport slave (
    input  load_valid_in, load_byte_in, load_done_in, start_in, halt_in,
    output load_ready_out, current_instruction_out, instruction_valid_out,
           program_counter_out, program_length_out, load_error_out,
           busy_out, done_out
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Packs a big-endian byte stream into a local instruction memory and then
// issues the stored words to the CPU one per clock, NOP_WORD otherwise.
module instruction_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          AW         = $clog2(IMEM_DEPTH),
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input logic                  clock_in,
  input logic                  reset_n_in,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(IMEM_DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   wordCount_q, wordCount_d;
  logic [1:0]    byteCount_q, byteCount_d;
  logic [23:0]   partial_q, partial_d;
  logic [AW:0]   length_q, length_d;
  logic          loadError_q, loadError_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;

  logic [31:0]   mem [IMEM_DEPTH];

  logic          canLoad, loadReady, accept, overflow;
  logic          fresh;
  logic [AW:0]   wcBase, packWc;
  logic [1:0]    bcBase, packBc;
  logic [23:0]   partialBase, packPartial;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic [AW-1:0] pcNext;
  logic          lastWord;

  assign canLoad   = (state_q != RUN);
  assign loadReady = canLoad && (wordCount_q < DEPTH);
  assign accept    = bus.load_valid_in && loadReady;
  assign overflow  = bus.load_valid_in && canLoad && (wordCount_q == DEPTH);
  assign pcNext    = pc_q + 1'b1;
  assign lastWord  = ({1'b0, pc_q} == (length_q - 1'b1));

  // A byte accepted outside LOAD begins a fresh image, so the packer starts
  // from cleared counters rather than whatever the last load left behind.
  always_comb begin
    fresh       = (state_q != LOAD);
    wcBase      = fresh ? '0 : wordCount_q;
    bcBase      = fresh ? 2'd0 : byteCount_q;
    partialBase = fresh ? 24'd0 : partial_q;
    packWc      = wcBase;
    packBc      = bcBase;
    packPartial = partialBase;
    memWe       = 1'b0;
    memAddr     = wcBase[AW-1:0];
    memData     = {partialBase, bus.load_byte_in};
    if (accept) begin
      if (bcBase == 2'd3) begin
        memWe  = 1'b1;
        packWc = wcBase + 1'b1;
        packBc = 2'd0;
      end else begin
        packBc      = bcBase + 2'd1;
        packPartial = {partialBase[15:0], bus.load_byte_in};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wordCount_d = wordCount_q;
    byteCount_d = byteCount_q;
    partial_d   = partial_q;
    length_d    = length_q;
    loadError_d = loadError_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d     = LOAD;
          wordCount_d = packWc;
          byteCount_d = packBc;
          partial_d   = packPartial;
          loadError_d = 1'b0;
        end else if (overflow) begin
          loadError_d = 1'b1;
        end else if (bus.start_in) begin
          if (length_q != '0) begin
            state_d = RUN;
            pc_d    = '0;
            instr_d = mem[0];
            valid_d = 1'b1;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
          end
        end
      end
      LOAD: begin
        wordCount_d = packWc;
        byteCount_d = packBc;
        partial_d   = packPartial;
        if (overflow) begin
          loadError_d = 1'b1;
        end
        if (bus.load_done_in) begin
          state_d     = IDLE;
          length_d    = packWc;
          byteCount_d = 2'd0;
          if (packBc != 2'd0) begin
            loadError_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.halt_in || lastWord) begin
          state_d = DONE;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          pc_d    = pcNext;
          instr_d = mem[pcNext];
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      wordCount_q <= '0;
      byteCount_q <= 2'd0;
      partial_q   <= 24'd0;
      length_q    <= '0;
      loadError_q <= 1'b0;
      instr_q     <= NOP_WORD;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wordCount_q <= wordCount_d;
      byteCount_q <= byteCount_d;
      partial_q   <= partial_d;
      length_q    <= length_d;
      loadError_q <= loadError_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  // Program memory survives reset so a loaded image is never scrubbed.
  always_ff @(posedge clock_in) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign bus.load_ready_out          = loadReady;
  assign bus.current_instruction_out = instr_q;
  assign bus.instruction_valid_out   = valid_q;
  assign bus.program_counter_out     = pc_q;
  assign bus.program_length_out      = length_q;
  assign bus.load_error_out          = loadError_q;
  assign bus.busy_out                = (state_q == LOAD) || (state_q == RUN);
  assign bus.done_out                = (state_q == DONE);

endmodule
